// File: rtl/magnetron_pwr_ctrl.sv
// Microwave magnetron power controller: synchronised front-panel inputs, a four-state
// cook FSM and a per-window duty cycle generator with a saturating energy counter.
module magnetron_pwr_ctrl #(
    parameter int PERIOD = 10,
    parameter int PWR_W  = 4,
    parameter int ON_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] power_level,
    output logic             mag_on,
    output logic [1:0]       state,
    output logic             done_pulse,
    output logic [ON_W-1:0]  on_cycles
);

    localparam int              WIN_W     = $clog2(PERIOD);
    localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(PERIOD - 1);
    localparam logic [31:0]     PERIOD_U  = 32'(PERIOD);
    // Bit order {timer_done, door_closed, clearn, stopn, startn}; reset to the inactive levels.
    localparam logic [4:0]      SYNC_RST  = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOK  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    logic [4:0]       raw_in;
    logic [4:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       vld_q, vld_d;
    logic [1:0]       prev_q, prev_d;
    state_e           state_q, state_d;
    logic [PWR_W-1:0] lvl_q, lvl_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             mag_on_q, mag_on_d;
    logic             done_pulse_q, done_pulse_d;
    logic [ON_W-1:0]  on_cycles_q, on_cycles_d;

    logic             start_ev, stop_ev, clear, door_open, tdone;
    logic             cook_entry;
    logic [31:0]      lvl_eff;

    assign raw_in = {timer_done, door_closed, clearn, stopn, startn};

    // prev_q stays 0 until a genuine sample reaches sync2, so a button already held
    // down when reset releases never looks like a fresh press.
    assign start_ev  = prev_q[0] & ~sync2_q[0];
    assign stop_ev   = prev_q[1] & ~sync2_q[1];
    assign clear     = ~sync2_q[2];
    assign door_open = ~sync2_q[3];
    assign tdone     = sync2_q[4];

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        vld_d   = {vld_q[0], 1'b1};
        prev_d  = vld_q[1] ? sync2_q[1:0] : 2'b00;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!clear && !tdone && !door_open && !stop_ev && start_ev)
                    state_d = ST_COOK;
            end
            ST_COOK: begin
                if (clear)                     state_d = ST_IDLE;
                else if (tdone)                state_d = ST_DONE;
                else if (door_open || stop_ev) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear)          state_d = ST_IDLE;
                else if (tdone)     state_d = ST_DONE;
                else if (door_open) state_d = ST_PAUSE;
                else if (stop_ev)   state_d = ST_IDLE;
                else if (start_ev)  state_d = ST_COOK;
            end
            ST_DONE: begin
                if (clear || door_open) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cook_entry = (state_d == ST_COOK) && (state_q != ST_COOK);
        lvl_d      = cook_entry ? power_level : lvl_q;

        if (state_d != ST_COOK || cook_entry) win_d = '0;
        else if (win_q == WIN_MAX)             win_d = '0;
        else                                   win_d = win_q + 1'b1;

        // A zero or out-of-range level means the magnetron stays on for the whole window.
        if (lvl_d == '0 || 32'(lvl_d) >= PERIOD_U) lvl_eff = PERIOD_U;
        else                                       lvl_eff = 32'(lvl_d);

        mag_on_d     = (state_d == ST_COOK) && (32'(win_d) < lvl_eff);
        done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);

        if (cook_entry && state_q == ST_IDLE)      on_cycles_d = '0;
        else if (mag_on_q && on_cycles_q != '1)    on_cycles_d = on_cycles_q + 1'b1;
        else                                       on_cycles_d = on_cycles_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= SYNC_RST;
            sync2_q      <= SYNC_RST;
            vld_q        <= 2'b00;
            prev_q       <= 2'b00;
            state_q      <= ST_IDLE;
            lvl_q        <= '0;
            win_q        <= '0;
            mag_on_q     <= 1'b0;
            done_pulse_q <= 1'b0;
            on_cycles_q  <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            vld_q        <= vld_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            win_q        <= win_d;
            mag_on_q     <= mag_on_d;
            done_pulse_q <= done_pulse_d;
            on_cycles_q  <= on_cycles_d;
        end
    end

    assign mag_on     = mag_on_q;
    assign state      = state_q;
    assign done_pulse = done_pulse_q;
    assign on_cycles  = on_cycles_q;

endmodule

// File: tb/tb_magnetron_pwr_ctrl.sv
// Directed bench for magnetron_pwr_ctrl: a per-cycle vector table for a full cook
// session plus hand-written sequences for pause, done, reset and saturation corners.
module tb_magnetron_pwr_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        startn, stopn, clearn, door_closed, timer_done;
    logic [3:0]  power_level;
    logic        mag_on, done_pulse;
    logic [1:0]  state;
    logic [15:0] on_cycles;
    logic        mag_on_s, done_pulse_s;
    logic [1:0]  state_s;
    logic [3:0]  on_cycles_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    magnetron_pwr_ctrl #(.PERIOD(10), .PWR_W(4), .ON_W(16)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
        .mag_on(mag_on), .state(state), .done_pulse(done_pulse), .on_cycles(on_cycles)
    );

    magnetron_pwr_ctrl #(.PERIOD(10), .PWR_W(4), .ON_W(4)) dut_sat (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
        .mag_on(mag_on_s), .state(state_s), .done_pulse(done_pulse_s), .on_cycles(on_cycles_s)
    );

    typedef struct {
        logic        startn;
        logic        stopn;
        logic [3:0]  pwr;
        logic [1:0]  exp_state;
        logic        exp_mag;
        logic        exp_done;
        logic [15:0] exp_on;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] pw);
        resetn      = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        timer_done  = 1'b0;
        power_level = pw;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (3) tick();
    endtask

    // One-cycle press of startn, then wait for the two-edge synchroniser delay.
    task automatic start_cook();
        startn = 1'b0;
        tick();
        startn = 1'b1;
        tick();
        tick();
    endtask

    function automatic vec_t mk(input logic sn, input logic pn, input logic [3:0] pw,
                                input logic [1:0] st, input logic mg, input logic dn,
                                input int on);
        vec_t v;
        v.startn    = sn;
        v.stopn     = pn;
        v.pwr       = pw;
        v.exp_state = st;
        v.exp_mag   = mg;
        v.exp_done  = dn;
        v.exp_on    = 16'(on);
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cook session at level 3: pulse start, run 53 COOK cycles (level change to 9
        // mid-cook must not matter), a stop press pauses, a second stop press cancels.
        vecs.push_back(mk(1'b0, 1'b1, 4'd3, 2'd0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(1'b1, 1'b1, 4'd3, 2'd0, 1'b0, 1'b0, 0));
        for (int k = 0; k <= 52; k++) begin
            int on_exp;
            on_exp = 3 * (k / 10) + (((k % 10) < 3) ? (k % 10) : 3);
            vecs.push_back(mk(1'b1, (k == 51) ? 1'b0 : 1'b1, (k >= 20) ? 4'd9 : 4'd3,
                              2'd1, ((k % 10) < 3), 1'b0, on_exp));
        end
        vecs.push_back(mk(1'b1, 1'b1, 4'd9, 2'd2, 1'b0, 1'b0, 18));
        vecs.push_back(mk(1'b1, 1'b0, 4'd9, 2'd2, 1'b0, 1'b0, 18));
        vecs.push_back(mk(1'b1, 1'b1, 4'd9, 2'd2, 1'b0, 1'b0, 18));
        vecs.push_back(mk(1'b1, 1'b1, 4'd9, 2'd0, 1'b0, 1'b0, 18));
        vecs.push_back(mk(1'b1, 1'b1, 4'd9, 2'd0, 1'b0, 1'b0, 18));

        // Reset values, checked while reset is still asserted and after release.
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power_level = 4'd3;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mag", 32'(mag_on), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_on", 32'(on_cycles), 32'd0);
        do_reset(4'd3);
        check("rel_state", 32'(state), 32'd0);
        check("rel_on_sat", 32'(on_cycles_s), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            startn      = vecs[i].startn;
            stopn       = vecs[i].stopn;
            power_level = vecs[i].pwr;
            tick();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_mag", i), 32'(mag_on), 32'(vecs[i].exp_mag));
            check($sformatf("vec%0d_done", i), 32'(done_pulse), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_on", i), 32'(on_cycles), 32'(vecs[i].exp_on));
        end

        // Full power at level 0, with the 4-bit energy counter saturating at 15.
        do_reset(4'd0);
        start_cook();
        for (int k = 0; k <= 20; k++) begin
            check($sformatf("full0_mag_k%0d", k), 32'(mag_on), 32'd1);
            check($sformatf("full0_on_k%0d", k), 32'(on_cycles), 32'(k));
            check($sformatf("sat_on_k%0d", k), 32'(on_cycles_s), (k < 15) ? 32'(k) : 32'd15);
            tick();
        end
        check("sat_state", 32'(state_s), 32'd1);
        check("sat_mag", 32'(mag_on_s), 32'd1);

        // Full power at an out-of-range level.
        do_reset(4'd12);
        start_cook();
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("full12_mag_k%0d", k), 32'(mag_on), 32'd1);
            tick();
        end

        // Door opens while mag_on would be high; re-entry restarts the window.
        do_reset(4'd3);
        start_cook();
        repeat (8) tick();
        door_closed = 1'b0;
        tick();
        check("door_k9_state", 32'(state), 32'd1);
        check("door_k9_mag", 32'(mag_on), 32'd0);
        tick();
        check("door_k10_mag", 32'(mag_on), 32'd1);
        tick();
        check("door_pause_state", 32'(state), 32'd2);
        check("door_pause_mag", 32'(mag_on), 32'd0);
        check("door_pause_on", 32'(on_cycles), 32'd4);
        repeat (3) tick();
        check("door_hold_on", 32'(on_cycles), 32'd4);
        door_closed = 1'b1;
        repeat (3) tick();
        check("door_closed_state", 32'(state), 32'd2);
        start_cook();
        check("resume_state", 32'(state), 32'd1);
        check("resume_mag0", 32'(mag_on), 32'd1);
        check("resume_on0", 32'(on_cycles), 32'd4);
        tick();
        check("resume_mag1", 32'(mag_on), 32'd1);
        check("resume_on1", 32'(on_cycles), 32'd5);
        tick();
        check("resume_mag2", 32'(mag_on), 32'd1);
        check("resume_on2", 32'(on_cycles), 32'd6);
        tick();
        check("resume_mag3", 32'(mag_on), 32'd0);
        check("resume_on3", 32'(on_cycles), 32'd7);

        // Timer expiry and stop in the same cycle: timer wins.
        do_reset(4'd3);
        start_cook();
        tick();
        timer_done = 1'b1;
        stopn      = 1'b0;
        tick();
        stopn = 1'b1;
        check("td_k2_mag", 32'(mag_on), 32'd1);
        tick();
        check("td_k3_state", 32'(state), 32'd1);
        check("td_k3_done", 32'(done_pulse), 32'd0);
        tick();
        check("td_done_state", 32'(state), 32'd3);
        check("td_done_pulse", 32'(done_pulse), 32'd1);
        check("td_done_mag", 32'(mag_on), 32'd0);
        check("td_done_on", 32'(on_cycles), 32'd3);
        check("td_sat_pulse", 32'(done_pulse_s), 32'd1);
        tick();
        check("td_pulse_once", 32'(done_pulse), 32'd0);
        check("td_state_hold", 32'(state), 32'd3);
        start_cook();
        check("td_start_ignored", 32'(state), 32'd3);
        check("td_start_mag", 32'(mag_on), 32'd0);
        check("td_on_hold", 32'(on_cycles), 32'd3);
        timer_done = 1'b0;
        clearn     = 1'b0;
        tick();
        clearn = 1'b1;
        tick();
        check("clr_pre_state", 32'(state), 32'd3);
        tick();
        check("clr_state", 32'(state), 32'd0);
        check("clr_done", 32'(done_pulse), 32'd0);

        // Door open in IDLE: start is refused.
        do_reset(4'd3);
        door_closed = 1'b0;
        repeat (3) tick();
        startn = 1'b0;
        tick();
        startn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("open_idle_state_%0d", k), 32'(state), 32'd0);
            check($sformatf("open_idle_mag_%0d", k), 32'(mag_on), 32'd0);
        end
        door_closed = 1'b1;

        // Reset mid-COOK drops mag_on at once; startn held across release is not a press.
        do_reset(4'd0);
        start_cook();
        repeat (3) tick();
        check("pre_rst_mag", 32'(mag_on), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_mag", 32'(mag_on), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_on", 32'(on_cycles), 32'd0);
        startn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("held_start_state_%0d", k), 32'(state), 32'd0);
        end
        startn = 1'b1;
        repeat (3) tick();
        start_cook();
        check("restart_state", 32'(state), 32'd1);
        check("restart_mag", 32'(mag_on), 32'd1);
        check("restart_on", 32'(on_cycles), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
